// File: rtl/seq_divider_pkg.sv
// Shared types and width constants for the iterative restoring divider.
// Holds the FSM state encoding and the iteration counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int DW = 16;
  localparam int VW = 8;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DW);

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master presents operands and consumes results; the divider is the slave.
interface seq_divider_if #(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, then subtract the divisor when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int VW = div_pkg::VW
) (
  input  logic [VW-1:0] r_reg,
  input  logic          q_msb,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] r_next,
  output logic          q_bit
);

  // The shifted partial remainder needs one extra bit, so the compare and
  // subtract run at VW+1 bits; after a subtract the result is below divisor.
  logic [VW:0] r_shift;
  logic [VW:0] r_diff;

  always_comb begin
    r_shift = {r_reg, q_msb};
    r_diff  = r_shift - {1'b0, divisor};
    q_bit   = (r_shift >= {1'b0, divisor});
    r_next  = q_bit ? r_diff[VW-1:0] : r_shift[VW-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, behind
// valid/ready handshakes on both the operand and the result side.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] r_reg;
  logic [VW-1:0] divisor_reg;
  logic [CW-1:0] counter;

  logic [VW-1:0] r_next;
  logic          q_bit;
  logic [DW-1:0] q_next;

  div_step #(.VW(VW)) u_step (
    .r_reg   (r_reg),
    .q_msb   (q_reg[DW-1]),
    .divisor (divisor_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  assign q_next = {q_reg[DW-2:0], q_bit};

  // Result registers only change on completion, so nothing partial is ever
  // visible; a zero divisor skips CALC and reports one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      q_reg           <= '0;
      r_reg           <= '0;
      divisor_reg     <= '0;
      counter         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            divisor_reg  <= bus.divisor;
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend[VW-1:0];
              bus.div_by_zero <= 1'b1;
            end else begin
              state   <= CALC;
              q_reg   <= bus.dividend;
              r_reg   <= '0;
              counter <= CW'(DW - 1);
            end
          end
        end

        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          if (counter == '0) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.quotient    <= q_next;
            bus.remainder   <= r_next;
            bus.div_by_zero <= 1'b0;
          end else begin
            counter <= counter - 1'b1;
          end
        end

        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end else begin
            bus.out_valid <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases followed by random
// operands against an arithmetic reference model with random result stalls.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_if #(.DW(16), .VW(8)) dif ();

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      $error("[TB] check %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor convention.
  function automatic void refDiv(input logic [15:0] a, input logic [7:0] b,
                                 output logic [15:0] q, output logic [7:0] r,
                                 output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      z = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b,
                               input int stall, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat;
    int          waitN;
    refDiv(a, b, eq, er, ez);

    waitN = 0;
    while (!dif.in_ready && waitN < 64) begin
      @(posedge clk); #1;
      waitN++;
    end
    checkOutput({tag, "_in_ready_idle"}, 32'(dif.in_ready), 32'd1);

    dif.in_valid  = 1'b1;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.out_ready = (stall == 0);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.dividend = 16'($urandom);
    dif.divisor  = 8'($urandom);

    lat = 0;
    while (!dif.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), (b == 8'd0) ? 32'd1 : 32'd16);
    checkOutput({tag, "_quotient"}, 32'(dif.quotient), 32'(eq));
    checkOutput({tag, "_remainder"}, 32'(dif.remainder), 32'(er));
    checkOutput({tag, "_div_by_zero"}, 32'(dif.div_by_zero), 32'(ez));
    if (b != 8'd0) begin
      checkOutput({tag, "_identity"},
                  32'(dif.quotient) * 32'(b) + 32'(dif.remainder), 32'(a));
      checkOutput({tag, "_rem_lt_div"}, 32'(dif.remainder < b), 32'd1);
    end

    for (int i = 0; i < stall; i++) begin
      dif.in_valid = 1'($urandom);
      dif.dividend = 16'($urandom);
      dif.divisor  = 8'($urandom);
      @(posedge clk); #1;
      checkOutput({tag, "_stall_valid"}, 32'(dif.out_valid), 32'd1);
      checkOutput({tag, "_stall_quotient"}, 32'(dif.quotient), 32'(eq));
      checkOutput({tag, "_stall_remainder"}, 32'(dif.remainder), 32'(er));
      checkOutput({tag, "_stall_in_ready"}, 32'(dif.in_ready), 32'd0);
    end

    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_valid_cleared"}, 32'(dif.out_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(dif.in_ready), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(dif.in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(dif.out_valid), 32'd0);
    checkOutput({tag, "_quotient"}, 32'(dif.quotient), 32'd0);
    checkOutput({tag, "_remainder"}, 32'(dif.remainder), 32'd0);
    checkOutput({tag, "_div_by_zero"}, 32'(dif.div_by_zero), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          sel;
    int          st;

    rst_n         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;
    #12;
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkResetValues("post_reset");

    $display("[TB] directed cases");
    applyStimulus(16'd1000, 8'd7, 0, "t1_1000_7");
    applyStimulus(16'hFFFF, 8'hFF, 0, "t2_ffff_ff");
    applyStimulus(16'd5, 8'd9, 0, "t2_5_9");
    applyStimulus(16'h1234, 8'd0, 0, "t3_dbz");
    applyStimulus(16'h0010, 8'd4, 0, "t3_after_dbz");
    applyStimulus(16'd50000, 8'd123, 10, "t4_stall");

    $display("[TB] reset during CALC");
    dif.in_valid  = 1'b1;
    dif.dividend  = 16'hBEEF;
    dif.divisor   = 8'd13;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    checkOutput("t5_busy_before_reset", 32'(dif.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkResetValues("t5_async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5_no_result_after_reset", 32'(dif.out_valid), 32'd0);
    applyStimulus(16'h0064, 8'd10, 0, "t5_after_reset");

    $display("[TB] random operands");
    for (int n = 0; n < 3000; n++) begin
      ra  = 16'($urandom);
      rb  = 8'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 8'd1;
        1: rb = 8'hFF;
        2: ra = 16'd0;
        3: ra = 16'hFFFF;
        default: ;
      endcase
      st = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      applyStimulus(ra, rb, st, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
